// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// MSB-first, nibble-serial unsigned magnitude comparator for two WIDTH-bit
// operands. Operands are captured on an accepted start. One 4-bit nibble is
// resolved per clock, and a one-hot lt/eq/gt result is reported with a
// single-cycle done pulse.
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN. When it is defined, the
// first unequal nibble ends the comparison immediately.
module serial_magnitude_comparator #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt_out,
   output logic             eq_out,
   output logic             gt_out
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [IDXW-1:0]   idx;
   logic              dec_lt;
   logic              dec_gt;
   logic [3:0]        a_nib;
   logic [3:0]        b_nib;
   logic              new_lt;
   logic              new_gt;
   logic              load;
   logic              finish;

   // Select the nibble currently addressed by idx from both captured operands
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx == IDXW'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end
   end

   // Fold the current nibble into the decision; an earlier decision always wins
   always_comb begin
      new_lt = dec_lt | (~dec_gt & (a_nib < b_nib));
      new_gt = dec_gt | (~dec_lt & (a_nib > b_nib));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic, datapath control strobes and status outputs
   always_comb begin
      state_next = state;
      load       = 1'b0;
      finish     = 1'b0;
      busy       = (state == COMPARE);
      done       = (state == DONE);
      case (state)
         IDLE: begin
            if (start) begin
               state_next = COMPARE;
               load       = 1'b1;
            end
         end
         COMPARE: begin
            if (idx == '0) begin
               state_next = DONE;
               finish     = 1'b1;
            end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            if (!dec_lt && !dec_gt && (a_nib != b_nib)) begin
               state_next = DONE;
               finish     = 1'b1;
            end
`else
`endif
         end
         DONE: begin
            if (start) begin
               state_next = COMPARE;
               load       = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand capture, nibble walk, decision tracking and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         dec_lt <= 1'b0;
         dec_gt <= 1'b0;
         lt_out <= 1'b0;
         eq_out <= 1'b1;
         gt_out <= 1'b0;
      end else if (load) begin
         a_q    <= a;
         b_q    <= b;
         idx    <= IDXW'(NIBBLES - 1);
         dec_lt <= 1'b0;
         dec_gt <= 1'b0;
      end else if (state == COMPARE) begin
         dec_lt <= new_lt;
         dec_gt <= new_gt;
         // Park idx at zero once the walk ends instead of letting it wrap
         idx    <= finish ? '0 : idx - IDXW'(1);
         if (finish) begin
            lt_out <= new_lt;
            eq_out <= ~(new_lt | new_gt);
            gt_out <= new_gt;
         end
      end
   end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Testbench for serial_magnitude_comparator (WIDTH=16). A transaction-level
// model predicts busy/done/result every cycle. Directed scenarios also pin
// latencies and results with hand-computed constants.
module tb_serial_magnitude_comparator;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned NIBBLES = WIDTH / 4;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic             lt_out;
   logic             eq_out;
   logic             gt_out;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Model state
   bit       m_busy = 1'b0;
   bit       m_done = 1'b0;
   bit [2:0] m_res  = 3'b010;   // {lt, eq, gt}
   bit [2:0] m_pend = 3'b010;
   int       m_cnt  = 0;

   serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (op_a),
      .b      (op_b),
      .busy   (busy),
      .done   (done),
      .lt_out (lt_out),
      .eq_out (eq_out),
      .gt_out (gt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic bit [2:0] ref_result(input bit [WIDTH-1:0] x, input bit [WIDTH-1:0] y);
      if (x < y) return 3'b100;
      if (x > y) return 3'b001;
      return 3'b010;
   endfunction

   function automatic int ref_latency(input bit [WIDTH-1:0] x, input bit [WIDTH-1:0] y);
      bit [WIDTH-1:0] dx;
      if (!EARLY) return NIBBLES;
      dx = x ^ y;
      for (int i = NIBBLES - 1; i >= 0; i--) begin
         if (dx[4*i +: 4] != 4'h0) return NIBBLES - i;
      end
      return NIBBLES;
   endfunction

   // Transaction-level model: an accepted start fixes result and latency up front
   always @(posedge clk) begin
      cyc++;
      m_done = 1'b0;
      if (rst) begin
         m_busy = 1'b0;
         m_cnt  = 0;
         m_res  = 3'b010;
      end else if (m_busy) begin
         m_cnt--;
         if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_res  = m_pend;
         end
      end else if (start) begin
         m_busy = 1'b1;
         m_cnt  = ref_latency(op_a, op_b);
         m_pend = ref_result(op_a, op_b);
      end
   end

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cycle_outputs", {27'd0, busy, done, lt_out, eq_out, gt_out},
             {27'd0, m_busy, m_done, m_res});
      end
   end

   task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      @(negedge clk);
      op_a  = av;
      op_b  = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 20);
      chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
   endtask

   task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input int exp_lat, input logic [2:0] exp_res, input string name);
      int t0;
      start_op(av, bv);
      t0 = cyc;
      wait_done(name);
      chk({name, "_latency"}, cyc - t0, exp_lat);
      chk({name, "_result"}, {29'd0, lt_out, eq_out, gt_out}, {29'd0, exp_res});
      @(negedge clk);
   endtask

   initial begin
      int t0;
      int t1;
      int t2;
      bit saw_done;
      logic [3:0] nb;

      rst   = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("reset_state", {27'd0, busy, done, lt_out, eq_out, gt_out}, {27'd0, 5'b00010});
      rst = 1'b0;
      @(negedge clk);

      // Equal operands, then the MSB-decided case
      do_op(16'h1234, 16'h1234, 4, 3'b010, "equal");
      do_op(16'h8000, 16'h7FFF, EARLY ? 1 : 4, 3'b001, "msb_gt");

      // LSB-decided case with an ignored start while busy
      start_op(16'h00A3, 16'h00A4);
      t0 = cyc;
      @(negedge clk);
      chk("busy_midway", {31'd0, busy}, 32'd1);
      op_a  = 16'hFFFF;
      op_b  = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("lsb_lt");
      chk("lsb_lt_latency", cyc - t0, 4);
      chk("lsb_lt_result", {29'd0, lt_out, eq_out, gt_out}, {29'd0, 3'b100});
      repeat (2) @(negedge clk);
      chk("ignored_start_no_done", {31'd0, done}, 32'd0);

      // Back-to-back with start held high
      @(negedge clk);
      op_a  = 16'h0001;
      op_b  = 16'h0000;
      start = 1'b1;
      wait_done("b2b_first");
      t1 = cyc;
      chk("b2b_first_result", {29'd0, lt_out, eq_out, gt_out}, {29'd0, 3'b001});
      op_a = 16'h0000;
      op_b = 16'h0001;
      wait_done("b2b_second");
      t2 = cyc;
      start = 1'b0;
      chk("b2b_spacing", t2 - t1, 5);
      chk("b2b_second_result", {29'd0, lt_out, eq_out, gt_out}, {29'd0, 3'b100});
      repeat (2) @(negedge clk);

      // Reset mid-comparison abandons the operation
      start_op(16'hF000, 16'h0FFF);
      if (!EARLY) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_outputs", {27'd0, busy, done, lt_out, eq_out, gt_out}, {27'd0, 5'b00010});
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", {31'd0, saw_done}, 32'd0);
      do_op(16'h4321, 16'h4322, 4, 3'b100, "after_abort");

      // Randomized traffic with nibble-level operand correlation and rare resets
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 80) == 0);
         start = ($urandom_range(0, 2) != 0);
         op_a  = WIDTH'($urandom);
         for (int i = 0; i < int'(NIBBLES); i++) begin
            nb = 4'($urandom_range(0, 15));
            op_b[4*i +: 4] = ($urandom_range(0, 1) == 0) ? op_a[4*i +: 4] : nb;
         end
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
